// File: rtl/hd_pkg.sv
// hd_pkg: shared types and helpers for the Hamming pair decoder.
//   hd_mode_t     - combine mode selected by the {f1,f2} flags
//   hd_n / hd_k   - codeword and data widths for R parity bits
//   hd_data_pos   - Hamming position (1-based) holding data bit idx
package hd_pkg;

  typedef enum logic [1:0] {
    HD_MODE_2A_ADD_B = 2'b00,  // 2*c1 + c2
    HD_MODE_2A_SUB_B = 2'b01,  // 2*c1 - c2
    HD_MODE_A_SUB_2B = 2'b10,  // c1 - 2*c2
    HD_MODE_A_ADD_2B = 2'b11   // c1 + 2*c2
  } hd_mode_t;

  localparam int HD_R_MIN = 3;
  localparam int HD_R_MAX = 6;

  function automatic int hd_n(input int r);
    return (1 << r) - 1;
  endfunction

  function automatic int hd_k(input int r);
    return hd_n(r) - r;
  endfunction

  // Data bits fill the non-power-of-two positions in ascending order.
  function automatic int hd_data_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 3; p < 128; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hd_sec_dec.sv
// hd_sec_dec: combinational single-error-correcting decode of one codeword.
//   code_word  in  N   received codeword, bit i = Hamming position i+1
//   data       out K   corrected two's-complement data field
//   f          out 1   received (pre-flip) value of the corrected bit, 0 if clean
//   err        out 1   a bit was corrected (syndrome non-zero)
module hd_sec_dec
  import hd_pkg::*;
#(
  parameter int R = 3,
  localparam int N = hd_n(R),
  localparam int K = hd_k(R)
) (
  input  logic        [N-1:0] code_word,
  output logic signed [K-1:0] data,
  output logic                f,
  output logic                err
);

  logic [R-1:0] syn;
  logic [N-1:0] fixed;

  always_comb begin
    syn = '0;
    for (int i = 0; i < N; i++) begin
      if (code_word[i]) syn = syn ^ R'(i + 1);
    end
  end

  // A zero syndrome matches no position, so clean words pass straight through.
  always_comb begin
    fixed = code_word;
    f     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (syn == R'(i + 1)) begin
        fixed[i] = ~code_word[i];
        f        = code_word[i];
      end
    end
  end

  assign err = |syn;

  for (genvar j = 0; j < K; j++) begin : g_data
    localparam int P = hd_data_pos(j);
    assign data[j] = fixed[P-1];
  end

endmodule

// File: rtl/hd_pipe_dec.sv
// hd_pipe_dec: two-stage pipelined Hamming SEC decoder for codeword pairs.
// Optional feature macro: HD_STAT_CNT_EN (adds stat_clr / err_cnt).
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake for {code_word1, code_word2} (N bits each)
//   out_valid/out_ready output handshake for out_n (K+2 signed) and out_err
//   out_err             [1]=code_word1 corrected, [0]=code_word2 corrected
//   stat_clr, err_cnt   saturating corrected-codeword counter (macro only)
// R (parity bits) is legal from 3 to 6.
module hd_pipe_dec
  import hd_pkg::*;
#(
  parameter int R = 3,
  localparam int N = hd_n(R),
  localparam int K = hd_k(R)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic        [N-1:0] code_word1,
  input  logic        [N-1:0] code_word2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [K+1:0] out_n,
  output logic        [1:0]   out_err
`ifdef HD_STAT_CNT_EN
  ,
  input  logic                stat_clr,
  output logic        [15:0]  err_cnt
`endif
);

  logic signed [K-1:0] d1, d2;
  logic                f1, f2, e1, e2;

  hd_sec_dec #(.R(R)) u_dec1 (.code_word(code_word1), .data(d1), .f(f1), .err(e1));
  hd_sec_dec #(.R(R)) u_dec2 (.code_word(code_word2), .data(d2), .f(f2), .err(e2));

  logic                s1_valid;
  logic signed [K-1:0] s1_c1, s1_c2;
  hd_mode_t            s1_mode;
  logic        [1:0]   s1_err;
  logic                s2_valid;
  logic                s2_ready;

  // A stage can take new contents when empty or when its occupant leaves now.
  assign s2_ready  = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_ready;
  assign out_valid = s2_valid;

  logic signed [K+1:0] a, b, comb;

  assign a = {{2{s1_c1[K-1]}}, s1_c1};
  assign b = {{2{s1_c2[K-1]}}, s1_c2};

  always_comb begin
    comb = '0;
    case (s1_mode)
      HD_MODE_2A_ADD_B: comb = (a <<< 1) + b;
      HD_MODE_2A_SUB_B: comb = (a <<< 1) - b;
      HD_MODE_A_SUB_2B: comb = a - (b <<< 1);
      HD_MODE_A_ADD_2B: comb = a + (b <<< 1);
      default:          comb = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_c1    <= '0;
      s1_c2    <= '0;
      s1_mode  <= HD_MODE_2A_ADD_B;
      s1_err   <= '0;
      s2_valid <= 1'b0;
      out_n    <= '0;
      out_err  <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_c1   <= d1;
          s1_c2   <= d2;
          s1_mode <= hd_mode_t'({f1, f2});
          s1_err  <= {e1, e2};
        end
      end
      if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_n   <= comb;
          out_err <= s1_err;
        end
      end
    end
  end

`ifdef HD_STAT_CNT_EN
  logic [16:0] cnt_sum;

  assign cnt_sum = {1'b0, err_cnt} + 17'(out_err[1]) + 17'(out_err[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (stat_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready) begin
      err_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_hd_pipe_dec.sv
// tb_hd_pipe_dec: self-checking bench for hd_pipe_dec (R=3).
// Build with HD_STAT_CNT_EN defined to also exercise the error counter.
module tb_hd_pipe_dec;

  localparam int R = 3;
  localparam int N = 7;
  localparam int K = 4;
  localparam int W = K + 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] code_word1;
  logic [N-1:0] code_word2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_n;
  logic [1:0]   out_err;
`ifdef HD_STAT_CNT_EN
  logic         stat_clr;
  logic [15:0]  err_cnt;
  int           exp_cnt = 0;
`endif

  hd_pipe_dec #(.R(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .code_word1 (code_word1),
    .code_word2 (code_word2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_n      (out_n),
    .out_err    (out_err)
`ifdef HD_STAT_CNT_EN
    ,
    .stat_clr   (stat_clr),
    .err_cnt    (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  typedef struct {
    logic [W-1:0] n;
    logic [1:0]   err;
    int           acc;
  } exp_t;

  exp_t q[$];

  // Reference decode straight from the Hamming rules.
  function automatic void mdec(input logic [N-1:0] cw, output int val, output bit f, output bit e);
    int syn;
    int idx;
    logic [N-1:0] fx;
    syn = 0;
    for (int p = 1; p <= N; p++) if (cw[p-1]) syn = syn ^ p;
    fx = cw;
    f  = 1'b0;
    e  = (syn != 0);
    if (syn != 0) begin
      f = cw[syn-1];
      fx[syn-1] = ~cw[syn-1];
    end
    val = 0;
    idx = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (fx[p-1]) val = val + (1 << idx);
        idx++;
      end
    end
    if (val >= (1 << (K - 1))) val = val - (1 << K);
  endfunction

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t m;
    int c1, c2, r;
    bit f1, f2, e1, e2;
    mdec(a, c1, f1, e1);
    mdec(b, c2, f2, e2);
    case ({f1, f2})
      2'b00:   r = 2 * c1 + c2;
      2'b01:   r = 2 * c1 - c2;
      2'b10:   r = c1 - 2 * c2;
      default: r = 2 * c2 + c1;
    endcase
    m.n   = W'(r);
    m.err = {e1, e2};
    m.acc = 0;
    return m;
  endfunction

  // Compare process: every non-reset cycle, then account for the coming edge.
  always @(negedge clk) begin
    bit   exp_ov;
    exp_t m;
    if (rst) begin
      q.delete();
`ifdef HD_STAT_CNT_EN
      exp_cnt = 0;
`endif
    end else begin
      exp_ov = (q.size() > 0) && (q[0].acc <= cyc - 1);
      chk("out_valid", out_valid, exp_ov);
      chk("in_ready", in_ready, !(q.size() >= 2 && !out_ready));
      if (exp_ov) begin
        chk("out_n", out_n, q[0].n);
        chk("out_err", out_err, q[0].err);
      end
`ifdef HD_STAT_CNT_EN
      chk("err_cnt", err_cnt, exp_cnt);
      if (stat_clr) exp_cnt = 0;
      else if (exp_ov && out_ready) begin
        exp_cnt = exp_cnt + q[0].err[1] + q[0].err[0];
        if (exp_cnt > 65535) exp_cnt = 65535;
      end
`endif
      if (exp_ov && out_ready) void'(q.pop_front());
      if (in_valid && in_ready) begin
        m = model(code_word1, code_word2);
        m.acc = cyc + 1;
        q.push_back(m);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) step();
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic single(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [W-1:0] en, input logic [1:0] ee);
    drain();
    code_word1 = a;
    code_word2 = b;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_early"}, out_valid, 1'b0);
    step();
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_n"}, out_n, en);
    chk({nm, "_err"}, out_err, ee);
    step();
  endtask

  logic [N-1:0] bp1[4];
  logic [N-1:0] bp2[4];

  initial begin
    exp_t m;
    int   k;
    int   seen;
    bit   acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    code_word1 = '0; code_word2 = '0;
`ifdef HD_STAT_CNT_EN
    stat_clr = 1'b0;
`endif
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_n", out_n, '0);
    chk("rst_out_err", out_err, 2'b00);
    chk("rst_in_ready", in_ready, 1'b1);
`ifdef HD_STAT_CNT_EN
    chk("rst_err_cnt", err_cnt, 16'h0);
`endif

    m = model(7'h1E, 7'h78); chk("pin_clean_n", m.n, 6'd4);  chk("pin_clean_err", m.err, 2'b00);
    m = model(7'h4F, 7'h4F); chk("pin_min_n", m.n, 6'b101000); chk("pin_min_err", m.err, 2'b11);
    m = model(7'h5E, 7'h7A); chk("pin_both_n", m.n, 6'h3F);

    single("clean", 7'h1E, 7'h78, 6'd4,       2'b00);
    single("f1",    7'h1F, 7'h78, 6'd7,       2'b10);
    single("f2",    7'h1E, 7'h7A, 6'd8,       2'b01);
    single("both",  7'h5E, 7'h7A, 6'h3F,      2'b11);
    single("min",   7'h4F, 7'h4F, 6'b101000,  2'b11);

    // Back-pressure: four pairs with out_ready low, then release.
    bp1[0] = 7'h1E; bp2[0] = 7'h78;
    bp1[1] = 7'h1F; bp2[1] = 7'h78;
    bp1[2] = 7'h1E; bp2[2] = 7'h7A;
    bp1[3] = 7'h4F; bp2[3] = 7'h4F;
    drain();
    out_ready = 1'b0;
    k = 0;
    code_word1 = bp1[0]; code_word2 = bp2[0]; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        k++;
        if (k < 4) begin code_word1 = bp1[k]; code_word2 = bp2[k]; end
        else in_valid = 1'b0;
      end
    end
    chk("bp_accepted", k, 2);
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_back_to_back", out_valid, 1'b1);
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        k++;
        if (k < 4) begin code_word1 = bp1[k]; code_word2 = bp2[k]; end
        else in_valid = 1'b0;
      end
    end
    chk("bp_all_accepted", k, 4);

    // Mid-stream reset with two pairs in flight.
    drain();
    out_ready = 1'b0;
    in_valid = 1'b1; code_word1 = 7'h1F; code_word2 = 7'h78;
    step();
    code_word1 = 7'h5E; code_word2 = 7'h7A;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
      step();
    end
    chk("mid_rst_discarded", seen, 0);

`ifdef HD_STAT_CNT_EN
    drain();
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
    @(negedge clk); chk("cnt_start", err_cnt, 16'd0);
    single("cnt_a", 7'h5E, 7'h7A, 6'h3F, 2'b11);
    single("cnt_b", 7'h1F, 7'h78, 6'd7,  2'b10);
    single("cnt_c", 7'h1E, 7'h78, 6'd4,  2'b00);
    drain();
    @(negedge clk); chk("cnt_three", err_cnt, 16'd3);
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
    @(negedge clk); chk("cnt_cleared", err_cnt, 16'd0);
    code_word1 = 7'h4F; code_word2 = 7'h4F; in_valid = 1'b1; out_ready = 1'b1;
    repeat (32800) step();
    drain();
    @(negedge clk); chk("cnt_saturated", err_cnt, 16'hFFFF);
    step();
    @(negedge clk); chk("cnt_sat_hold", err_cnt, 16'hFFFF);
`endif

    // Randomized traffic, back-pressure and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      code_word1 = N'($urandom);
      code_word2 = N'($urandom);
      rst        = ($urandom_range(0, 299) == 0);
`ifdef HD_STAT_CNT_EN
      stat_clr   = ($urandom_range(0, 199) == 0);
`endif
      step();
    end
    rst = 1'b0;
`ifdef HD_STAT_CNT_EN
    stat_clr = 1'b0;
`endif
    drain();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
